// File: rtl/fp16_div_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fp16_div_arbiter
// Brief    : Round-robin arbiter sharing one fp16 divider among NUM_REQ
//            requesters, with divider-completion timeout.
// Revision : 1.0 - initial release
// ============================================================================
module fp16_div_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [NUM_REQ*16-1:0]  req_a,
   input  logic [NUM_REQ*16-1:0]  req_b,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic [NUM_REQ-1:0]     rsp_valid,
   input  logic [NUM_REQ-1:0]     rsp_ready,
   output logic [15:0]            rsp_data,
   output logic                   rsp_timeout,
   output logic [15:0]            div_a,
   output logic [15:0]            div_b,
   output logic                   div_start,
   output logic                   div_clear,
   input  logic                   div_valid,
   input  logic [15:0]            div_result,
   output logic                   busy,
   output logic [15:0]            done_count
);

   localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int c_CNT_W = $clog2(TIMEOUT + 1);

   localparam logic [2:0] c_IDLE  = 3'd0;
   localparam logic [2:0] c_START = 3'd1;
   localparam logic [2:0] c_WAIT  = 3'd2;
   localparam logic [2:0] c_CLEAR = 3'd3;
   localparam logic [2:0] c_RESP  = 3'd4;

   localparam logic [15:0] c_QNAN = 16'h7E00;

   logic [2:0]          r_state;
   logic [c_IDX_W-1:0]  r_last_grant;
   logic [15:0]         r_op_a;
   logic [15:0]         r_op_b;
   logic [15:0]         r_rsp_data;
   logic                r_rsp_timeout;
   logic [15:0]         r_done_count;
   logic [c_CNT_W-1:0]  r_wait_cnt;

   logic                w_grant_found;
   logic [c_IDX_W-1:0]  w_grant_idx;
   logic [c_IDX_W-1:0]  w_cand;
   logic                w_rsp_hs;
   logic                w_wait_expired;

   // Round-robin search starting just after the previous winner, wrapping.
   always_comb begin
      w_grant_found = 1'b0;
      w_grant_idx   = r_last_grant;
      w_cand        = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_cand = c_IDX_W'((int'(r_last_grant) + k) % NUM_REQ);
         if (!w_grant_found && req_valid[w_cand]) begin
            w_grant_found = 1'b1;
            w_grant_idx   = w_cand;
         end
      end
   end

   assign w_rsp_hs       = (r_state == c_RESP) && rsp_ready[r_last_grant];
   assign w_wait_expired = (r_wait_cnt == c_CNT_W'(TIMEOUT - 1));

   assign req_ready   = ((r_state == c_IDLE) && w_grant_found) ?
                        (NUM_REQ'(1) << w_grant_idx) : '0;
   assign rsp_valid   = (r_state == c_RESP) ? (NUM_REQ'(1) << r_last_grant) : '0;
   assign rsp_data    = r_rsp_data;
   assign rsp_timeout = r_rsp_timeout;
   assign div_a       = r_op_a;
   assign div_b       = r_op_b;
   assign div_start   = (r_state == c_START);
   assign div_clear   = (r_state == c_CLEAR);
   assign busy        = (r_state != c_IDLE);
   assign done_count  = r_done_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= c_IDLE;
         r_last_grant  <= c_IDX_W'(NUM_REQ - 1);
         r_op_a        <= '0;
         r_op_b        <= '0;
         r_rsp_data    <= '0;
         r_rsp_timeout <= 1'b0;
         r_done_count  <= '0;
         r_wait_cnt    <= '0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (w_grant_found) begin
                  r_op_a       <= req_a[16*w_grant_idx +: 16];
                  r_op_b       <= req_b[16*w_grant_idx +: 16];
                  r_last_grant <= w_grant_idx;
                  r_state      <= c_START;
               end
            end
            c_START: begin
               r_wait_cnt <= '0;
               r_state    <= c_WAIT;
            end
            c_WAIT: begin
               r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
               // A result arriving on the last allowed cycle beats the timeout.
               if (div_valid) begin
                  r_rsp_data    <= div_result;
                  r_rsp_timeout <= 1'b0;
                  r_state       <= c_CLEAR;
               end else if (w_wait_expired) begin
                  r_rsp_data    <= c_QNAN;
                  r_rsp_timeout <= 1'b1;
                  r_state       <= c_CLEAR;
               end
            end
            c_CLEAR: begin
               r_state <= c_RESP;
            end
            c_RESP: begin
               if (w_rsp_hs) begin
                  r_done_count <= r_done_count + 16'd1;
                  r_state      <= c_IDLE;
               end
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fp16_div_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp16_div_arbiter
// Brief    : Directed self-checking bench for fp16_div_arbiter with a
//            behavioural divider of programmable latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp16_div_arbiter;

   localparam int NUM_REQ = 4;
   localparam int TIMEOUT = 64;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ*16-1:0] req_a;
   logic [NUM_REQ*16-1:0] req_b;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ-1:0]    rsp_valid;
   logic [NUM_REQ-1:0]    rsp_ready;
   logic [15:0]           rsp_data;
   logic                  rsp_timeout;
   logic [15:0]           div_a;
   logic [15:0]           div_b;
   logic                  div_start;
   logic                  div_clear;
   logic                  div_valid;
   logic [15:0]           div_result;
   logic                  busy;
   logic [15:0]           done_count;

   int checks   = 0;
   int errors   = 0;
   int exp_done = 0;

   always #5 clk = ~clk;

   fp16_div_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
      .div_a(div_a), .div_b(div_b), .div_start(div_start), .div_clear(div_clear),
      .div_valid(div_valid), .div_result(div_result),
      .busy(busy), .done_count(done_count)
   );

   // Divider model: div_valid rises mdl_lat cycles after the div_start cycle.
   int          dcnt      = -1;
   int          mdl_lat   = 1;
   logic        mdl_never = 1'b0;
   logic [15:0] mdl_res   = 16'h0000;

   function automatic logic [15:0] lookup(input logic [15:0] a, input logic [15:0] b);
      if (a == 16'h4200 && b == 16'h3E00) return 16'h4000;
      if (a == 16'h4400 && b == 16'h3C00) return 16'h4400;
      if (a == 16'h3C00 && b == 16'h4400) return 16'h3400;
      return 16'hDEAD;
   endfunction

   always @(posedge clk) begin
      if (reset || div_clear) begin
         dcnt <= -1;
      end else if (div_start) begin
         dcnt    <= mdl_lat - 1;
         mdl_res <= lookup(div_a, div_b);
      end else if (dcnt > 0) begin
         dcnt <= dcnt - 1;
      end
   end

   assign div_valid  = (dcnt == 0) && !mdl_never;
   assign div_result = mdl_res;

   task automatic set_req(input int idx, input logic [15:0] a, input logic [15:0] b);
      req_a[16*idx +: 16] = a;
      req_b[16*idx +: 16] = b;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset    = 1'b0;
      exp_done = 0;
   endtask

   // Grant, divide and wait for the response; exp_n counts cycles from grant edge to rsp_valid.
   task automatic run_op(input int g, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_data, input logic exp_to,
                         input int exp_n, input bit drop);
      int n, starts, clears, overlap;
      logic [NUM_REQ-1:0] oh;
      oh = '0;
      oh[g] = 1'b1;
      #1;
      checks++;
      if (req_ready !== oh) begin
         errors++;
         $display("FAIL grant_ready g%0d: got %b want %b", g, req_ready, oh);
      end
      @(posedge clk);
      #1;
      if (drop) req_valid[g] = 1'b0;
      checks++;
      if (div_a !== a || div_b !== b || busy !== 1'b1 || req_ready !== '0) begin
         errors++;
         $display("FAIL operands g%0d: got a=%h b=%h busy=%b rdy=%b want a=%h b=%h busy=1 rdy=0",
                  g, div_a, div_b, busy, req_ready, a, b);
      end
      n = 0; starts = 0; clears = 0; overlap = 0;
      while (rsp_valid === '0 && n < TIMEOUT + 20) begin
         if (div_start === 1'b1) starts++;
         if (div_clear === 1'b1) clears++;
         if (div_start === 1'b1 && div_clear === 1'b1) overlap++;
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (n != exp_n) begin
         errors++;
         $display("FAIL latency g%0d: got %0d cycles want %0d", g, n, exp_n);
      end
      checks++;
      if (starts != 1 || clears != 1 || overlap != 0) begin
         errors++;
         $display("FAIL pulses g%0d: got start=%0d clear=%0d overlap=%0d want 1 1 0",
                  g, starts, clears, overlap);
      end
      checks++;
      if (rsp_valid !== oh || rsp_data !== exp_data || rsp_timeout !== exp_to) begin
         errors++;
         $display("FAIL response g%0d: got vld=%b data=%h to=%b want vld=%b data=%h to=%b",
                  g, rsp_valid, rsp_data, rsp_timeout, oh, exp_data, exp_to);
      end
   endtask

   // Optionally stall the response, then handshake it.
   task automatic complete(input int g, input int hold);
      logic [NUM_REQ-1:0] oh, v0;
      logic [15:0] d0;
      logic t0;
      bit stable;
      oh = '0;
      oh[g] = 1'b1;
      v0 = rsp_valid; d0 = rsp_data; t0 = rsp_timeout;
      stable = 1'b1;
      rsp_ready = ~oh;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         if (rsp_valid !== v0 || rsp_data !== d0 || rsp_timeout !== t0 ||
             req_ready !== '0 || busy !== 1'b1) stable = 1'b0;
      end
      if (hold > 0) begin
         checks++;
         if (!stable) begin
            errors++;
            $display("FAIL backpressure g%0d: got vld=%b data=%h rdy=%b want vld=%b data=%h rdy=0",
                     g, rsp_valid, rsp_data, req_ready, v0, d0);
         end
      end
      rsp_ready = oh;
      @(posedge clk);
      #1;
      rsp_ready = '0;
      exp_done++;
      checks++;
      if (done_count !== 16'(exp_done) || busy !== 1'b0 || rsp_valid !== '0) begin
         errors++;
         $display("FAIL handshake g%0d: got done=%0d busy=%b vld=%b want done=%0d busy=0 vld=0",
                  g, done_count, busy, rsp_valid, exp_done);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = '0;
      do_reset();
      checks++;
      if (busy !== 1'b0 || req_ready !== '0 || rsp_valid !== '0) begin
         errors++;
         $display("FAIL reset_ctrl: got busy=%b rdy=%b vld=%b want 0", busy, req_ready, rsp_valid);
      end
      checks++;
      if (div_start !== 1'b0 || div_clear !== 1'b0 || done_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_div: got start=%b clear=%b done=%0d want 0", div_start, div_clear, done_count);
      end
      checks++;
      if (rsp_data !== 16'h0 || rsp_timeout !== 1'b0 || div_a !== 16'h0 || div_b !== 16'h0) begin
         errors++;
         $display("FAIL reset_data: got data=%h to=%b a=%h b=%h want 0", rsp_data, rsp_timeout, div_a, div_b);
      end
   endtask

   task automatic test_single_op();
      set_req(0, 16'h4200, 16'h3E00);
      req_valid = 4'b0001;
      mdl_lat   = 2;
      run_op(0, 16'h4200, 16'h3E00, 16'h4000, 1'b0, 4, 1'b1);
      complete(0, 0);
   endtask

   task automatic test_round_robin();
      int order[5] = '{0, 1, 2, 3, 0};
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 16'h4400, 16'h3C00);
      req_valid = 4'b1111;
      mdl_lat   = 1;
      for (int i = 0; i < 5; i++) begin
         run_op(order[i], 16'h4400, 16'h3C00, 16'h4400, 1'b0, 3, 1'b0);
         complete(order[i], 0);
      end
   endtask

   task automatic test_backpressure();
      mdl_lat = 3;
      run_op(1, 16'h4400, 16'h3C00, 16'h4400, 1'b0, 5, 1'b0);
      complete(1, 10);
      req_valid = '0;
   endtask

   task automatic test_timeout();
      set_req(2, 16'h4200, 16'h3E00);
      req_valid = 4'b0100;
      mdl_never = 1'b1;
      run_op(2, 16'h4200, 16'h3E00, 16'h7E00, 1'b1, TIMEOUT + 2, 1'b1);
      complete(2, 0);
      mdl_never = 1'b0;
   endtask

   task automatic test_collision();
      set_req(3, 16'h4200, 16'h3E00);
      req_valid = 4'b1000;
      mdl_lat   = TIMEOUT;
      run_op(3, 16'h4200, 16'h3E00, 16'h4000, 1'b0, TIMEOUT + 2, 1'b1);
      complete(3, 0);
   endtask

   task automatic test_reset_mid_wait();
      bit quiet;
      set_req(1, 16'h4400, 16'h3C00);
      req_valid = 4'b0010;
      mdl_never = 1'b1;
      @(posedge clk);
      #1;
      req_valid = '0;
      repeat (6) @(posedge clk);
      #1;
      reset = 1'b1;
      quiet = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (div_clear !== 1'b0 || rsp_valid !== '0) quiet = 1'b0;
      end
      reset     = 1'b0;
      exp_done  = 0;
      mdl_never = 1'b0;
      checks++;
      if (!quiet || busy !== 1'b0 || done_count !== 16'd0 || rsp_data !== 16'h0) begin
         errors++;
         $display("FAIL abort: got quiet=%b busy=%b done=%0d data=%h want 1 0 0 0000",
                  quiet, busy, done_count, rsp_data);
      end
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 16'h3C00, 16'h4400);
      req_valid = 4'b1111;
      mdl_lat   = 2;
      run_op(0, 16'h3C00, 16'h4400, 16'h3400, 1'b0, 4, 1'b1);
      complete(0, 0);
      req_valid = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single_op();
      test_round_robin();
      test_backpressure();
      test_timeout();
      test_collision();
      test_reset_mid_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
